// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cycles backpressure counter.
module pipe_stage_reg #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q, main_d, skid_d;
  logic main_v, skid_v, in_fire, out_fire;
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: WIDTH and CNT_W must be positive");
  end
  assign main_v    = state_q != EMPTY;
  assign skid_v    = state_q == FULL;
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_v ? main_q : '0;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        main_d  = in_data;
      end
      ONE: if (in_fire && out_fire) main_d = in_data;
      else if (in_fire) begin
        state_d = FULL;
        skid_d  = in_data;
      end else if (out_fire) state_d = EMPTY;
      FULL: if (out_fire) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // an out fire alongside flush has already been taken downstream; only held entries drop
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) stall_cycles <= '0;
    else if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_pipe_stage_reg;
  logic CLK = 0, RST = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in_data = 0, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] stall_cycles;
`endif
  int total = 0, bad = 0, delivered = 0, base;
  logic [7:0] sb[$];
  logic [7:0] exp_d;
  pipe_stage_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  always @(negedge CLK) begin
    if (out_valid && out_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected none at %0t", out_data, $time);
      end else begin
        exp_d = sb.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, exp_d});
      end
    end
    if (out_valid === 1'b0) chk("bubble_zero", {24'd0, out_data}, 0);
    if (RST || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall", {28'd0, stall_cycles}, 0);
`endif
    RST = 0;
    out_ready = 1;
    for (int d = 1; d <= 4; d++) begin
      in_valid = 1;
      in_data = 8'(d);
      chk("stream_in_ready", {31'd0, in_ready}, 1);
      if (d > 1) chk("stream_latency", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'(d - 1)});
      step();
    end
    in_valid = 0;
    step();
    chk("stream_drained", {31'd0, out_valid}, 0);
    in_valid = 1;
    in_data = 8'h0A;
    step();
    out_ready = 0;
    in_data = 8'h0B;
    chk("bp_ready_one", {31'd0, in_ready}, 1);
    chk("bp_main_a", {24'd0, out_data}, 8'h0A);
    step();
    in_data = 8'h0C;
    chk("bp_ready_full", {31'd0, in_ready}, 0);
    step();
    chk("bp_hold_ready", {31'd0, in_ready}, 0);
    chk("bp_hold_a", {24'd0, out_data}, 8'h0A);
    out_ready = 1;
    step();
    chk("bp_recover_ready", {31'd0, in_ready}, 1);
    chk("bp_main_b", {24'd0, out_data}, 8'h0B);
    step();
    chk("bp_main_c", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h0C});
    in_valid = 0;
    step();
    chk("bp_drained", {31'd0, out_valid}, 0);
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h10;
    step();
    in_data = 8'h11;
    step();
    in_data = 8'h12;
    flush = 1;
    chk("fl_full_ready", {31'd0, in_ready}, 0);
    step();
    flush = 0;
    in_valid = 0;
    chk("fl_out_valid", {31'd0, out_valid}, 0);
    chk("fl_out_data", {24'd0, out_data}, 0);
    chk("fl_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1;
    repeat (3) step();
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h20;
    step();
    in_valid = 0;
    out_ready = 1;
    flush = 1;
    base = delivered;
    step();
    flush = 0;
    chk("flo_delivered_once", 32'(delivered - base), 1);
    chk("flo_empty", {30'd0, out_valid, in_ready}, 32'b01);
    step();
    chk("flo_no_repeat", 32'(delivered - base), 1);
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h30;
    step();
    in_data = 8'h31;
    step();
    in_valid = 0;
    RST = 1;
    step();
    RST = 0;
    chk("mrst_out_valid", {31'd0, out_valid}, 0);
    chk("mrst_in_ready", {31'd0, in_ready}, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("mrst_stall", {28'd0, stall_cycles}, 0);
`endif
    out_ready = 1;
    repeat (3) step();
`ifdef PIPE_STAGE_PERF_EN
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h40;
    step();
    in_valid = 0;
    repeat (5) step();
    chk("perf_partial", {28'd0, stall_cycles}, 5);
    repeat (15) step();
    chk("perf_saturate", {28'd0, stall_cycles}, 15);
    flush = 1;
    step();
    flush = 0;
    chk("perf_after_flush", {28'd0, stall_cycles}, 15);
    chk("perf_flush_empty", {31'd0, out_valid}, 0);
`endif
    step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
